// File: rtl/rf_wr_sched.sv
// Register-file write-port scheduler: pipeline writeback has fixed priority over a
// 2-entry long-latency-unit FIFO, with a pending-destination scoreboard for decode stalls.
module rf_wr_sched (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_wb_valid,
    input  logic [4:0]  i_wb_addr,
    input  logic [31:0] i_wb_data,
    input  logic        i_lu_valid,
    input  logic [4:0]  i_lu_addr,
    input  logic [31:0] i_lu_data,
    output logic        o_lu_ready,
    input  logic        i_issue_valid,
    input  logic [4:0]  i_issue_rd,
    input  logic [4:0]  i_rs1,
    input  logic [4:0]  i_rs2,
    output logic        o_stall,
    output logic        o_wr_en,
    output logic [4:0]  o_wr_addr,
    output logic [31:0] o_wr_data,
    output logic        o_err
);

    // LU handshake: a request transfers on a cycle where i_lu_valid & o_lu_ready are both 1;
    // o_lu_ready depends only on registered state, never on i_lu_valid.
    logic [4:0]  fifo_addr [2];
    logic [31:0] fifo_data [2];
    logic        wr_ptr;
    logic        rd_ptr;
    logic [1:0]  count;
    logic [31:0] pending;
    logic [31:0] pending_nxt;
    logic        from_fifo;
    logic        push;
    logic        pop;
    logic        issue_set;
    logic        fifo_full;

    assign fifo_full  = (count == 2'd2);
    assign o_lu_ready = (count < 2'd2);
    assign push       = i_lu_valid & o_lu_ready;
    // The FIFO head only reaches the port in cycles the pipeline does not claim it.
    assign pop        = ~i_wb_valid & (count != 2'd0);

    assign o_stall = pending[i_rs1] | pending[i_rs2]
                   | (i_issue_valid & pending[i_issue_rd])
                   | (i_issue_valid & fifo_full);

    assign issue_set = i_issue_valid & ~o_stall & (i_issue_rd != 5'd0);

    always_comb begin
        pending_nxt = pending;
        if (o_wr_en && from_fifo) begin
            pending_nxt[o_wr_addr] = 1'b0;
        end
        // A new reservation of the same register overrides the retiring write.
        if (issue_set) begin
            pending_nxt[i_issue_rd] = 1'b1;
        end
        pending_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr[wr_ptr] <= i_lu_addr;
            fifo_data[wr_ptr] <= i_lu_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= 1'b0;
            rd_ptr    <= 1'b0;
            count     <= 2'd0;
            pending   <= 32'd0;
            from_fifo <= 1'b0;
            o_wr_en   <= 1'b0;
            o_wr_addr <= 5'd0;
            o_wr_data <= 32'd0;
            o_err     <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + {1'b0, push} - {1'b0, pop};

            if (i_wb_valid) begin
                o_wr_en   <= (i_wb_addr != 5'd0);
                o_wr_addr <= i_wb_addr;
                o_wr_data <= i_wb_data;
                from_fifo <= 1'b0;
            end else if (pop) begin
                o_wr_en   <= (fifo_addr[rd_ptr] != 5'd0);
                o_wr_addr <= fifo_addr[rd_ptr];
                o_wr_data <= fifo_data[rd_ptr];
                from_fifo <= 1'b1;
            end else begin
                o_wr_en   <= 1'b0;
                from_fifo <= 1'b0;
            end

            pending <= pending_nxt;
            if (i_wb_valid && (i_wb_addr != 5'd0) && pending[i_wb_addr]) begin
                o_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_rf_wr_sched.sv
// Bench for rf_wr_sched: directed vector table, hand-written corner sequences and
// random traffic, all checked against a queue-based reference model.
module tb_rf_wr_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_wb_valid;
    logic [4:0]  i_wb_addr;
    logic [31:0] i_wb_data;
    logic        i_lu_valid;
    logic [4:0]  i_lu_addr;
    logic [31:0] i_lu_data;
    logic        o_lu_ready;
    logic        i_issue_valid;
    logic [4:0]  i_issue_rd;
    logic [4:0]  i_rs1;
    logic [4:0]  i_rs2;
    logic        o_stall;
    logic        o_wr_en;
    logic [4:0]  o_wr_addr;
    logic [31:0] o_wr_data;
    logic        o_err;

    rf_wr_sched dut (
        .clk(clk), .rst(rst),
        .i_wb_valid(i_wb_valid), .i_wb_addr(i_wb_addr), .i_wb_data(i_wb_data),
        .i_lu_valid(i_lu_valid), .i_lu_addr(i_lu_addr), .i_lu_data(i_lu_data),
        .o_lu_ready(o_lu_ready),
        .i_issue_valid(i_issue_valid), .i_issue_rd(i_issue_rd),
        .i_rs1(i_rs1), .i_rs2(i_rs2),
        .o_stall(o_stall),
        .o_wr_en(o_wr_en), .o_wr_addr(o_wr_addr), .o_wr_data(o_wr_data),
        .o_err(o_err)
    );

    // clock / reset
    always #5 clk = ~clk;

    typedef struct {
        logic        wb_v;
        logic [4:0]  wb_a;
        logic [31:0] wb_d;
        logic        lu_v;
        logic [4:0]  lu_a;
        logic [31:0] lu_d;
        logic        iss_v;
        logic [4:0]  iss_rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
    } in_t;

    typedef struct {
        in_t         in;
        logic        e_ready;
        logic        e_stall;
        logic        e_wr_en;
        logic [4:0]  e_addr;
        logic [31:0] e_data;
    } vec_t;

    int total = 0;
    int bad   = 0;

    // reference model state
    logic [36:0] exp_q[$];
    bit          pend [32];
    bit          m_err;
    bit          cur_en;
    bit          cur_ff;
    logic [4:0]  cur_a;
    logic [31:0] cur_d;
    logic        obs_ready;
    logic        obs_stall;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic in_t idle();
        in_t x;
        x = '{default: '0};
        return x;
    endfunction

    task automatic model_reset();
        exp_q.delete();
        for (int i = 0; i < 32; i++) pend[i] = 1'b0;
        m_err  = 1'b0;
        cur_en = 1'b0;
        cur_ff = 1'b0;
        cur_a  = '0;
        cur_d  = '0;
    endtask

    // One clock cycle: drive, check combinational outputs, step model, check registered outputs.
    task automatic cycle(input in_t x, input logic r);
        bit          e_ready;
        bit          e_stall;
        bit          accept;
        bit          issue_ok;
        bit          n_en;
        bit          n_ff;
        logic [4:0]  n_a;
        logic [31:0] n_d;
        logic [36:0] e;
        rst = r;
        i_wb_valid = x.wb_v;  i_wb_addr = x.wb_a;  i_wb_data = x.wb_d;
        i_lu_valid = x.lu_v;  i_lu_addr = x.lu_a;  i_lu_data = x.lu_d;
        i_issue_valid = x.iss_v; i_issue_rd = x.iss_rd;
        i_rs1 = x.rs1; i_rs2 = x.rs2;
        #1;
        e_ready = (exp_q.size() < 2);
        e_stall = pend[x.rs1] || pend[x.rs2] || (x.iss_v && pend[x.iss_rd])
                  || (x.iss_v && exp_q.size() == 2);
        obs_ready = o_lu_ready;
        obs_stall = o_stall;
        chk("model_lu_ready", {31'd0, o_lu_ready}, {31'd0, e_ready});
        chk("model_stall", {31'd0, o_stall}, {31'd0, e_stall});

        accept   = x.lu_v && e_ready;
        issue_ok = x.iss_v && !e_stall && (x.iss_rd != 0);
        n_en = 1'b0; n_ff = 1'b0; n_a = cur_a; n_d = cur_d;
        if (x.wb_v) begin
            n_en = (x.wb_a != 0); n_a = x.wb_a; n_d = x.wb_d;
        end else if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_a = e[36:32]; n_d = e[31:0]; n_en = (n_a != 0); n_ff = 1'b1;
        end
        if (accept) exp_q.push_back({x.lu_a, x.lu_d});
        if (x.wb_v && x.wb_a != 0 && pend[x.wb_a]) m_err = 1'b1;
        if (cur_en && cur_ff) pend[cur_a] = 1'b0;
        if (issue_ok) pend[x.iss_rd] = 1'b1;
        cur_en = n_en; cur_ff = n_ff; cur_a = n_a; cur_d = n_d;
        if (r) model_reset();

        @(posedge clk);
        #1;
        chk("model_wr_en", {31'd0, o_wr_en}, {31'd0, cur_en});
        if (cur_en) begin
            chk("model_wr_addr", {27'd0, o_wr_addr}, {27'd0, cur_a});
            chk("model_wr_data", o_wr_data, cur_d);
        end
        chk("model_err", {31'd0, o_err}, {31'd0, m_err});
    endtask

    task automatic do_reset();
        cycle(idle(), 1'b1);
        rst = 1'b0;
    endtask

    function automatic in_t wb(input logic [4:0] a, input logic [31:0] d);
        in_t x = idle();
        x.wb_v = 1'b1; x.wb_a = a; x.wb_d = d;
        return x;
    endfunction

    vec_t vecs [7];
    in_t  t;

    initial begin
        rst = 1'b1;
        i_wb_valid = 0; i_wb_addr = 0; i_wb_data = 0;
        i_lu_valid = 0; i_lu_addr = 0; i_lu_data = 0;
        i_issue_valid = 0; i_issue_rd = 0; i_rs1 = 0; i_rs2 = 0;
        model_reset();
        @(posedge clk);
        #1;
        do_reset();

        // reset state
        chk("reset_wr_en", {31'd0, o_wr_en}, 32'd0);
        chk("reset_wr_addr", {27'd0, o_wr_addr}, 32'd0);
        chk("reset_wr_data", o_wr_data, 32'd0);
        chk("reset_err", {31'd0, o_err}, 32'd0);

        // directed table: WB-only write, then WB/LU contention
        vecs[0] = '{wb(5'd5, 32'hDEADBEEF), 1'b1, 1'b0, 1'b1, 5'd5, 32'hDEADBEEF};
        t = wb(5'd3, 32'h33); t.lu_v = 1'b1; t.lu_a = 5'd7; t.lu_d = 32'h11;
        vecs[1] = '{t, 1'b1, 1'b0, 1'b1, 5'd3, 32'h33};
        t.lu_a = 5'd8; t.lu_d = 32'h22;
        vecs[2] = '{t, 1'b1, 1'b0, 1'b1, 5'd3, 32'h33};
        vecs[3] = '{wb(5'd3, 32'h33), 1'b0, 1'b0, 1'b1, 5'd3, 32'h33};
        vecs[4] = '{idle(), 1'b0, 1'b0, 1'b1, 5'd7, 32'h11};
        vecs[5] = '{idle(), 1'b1, 1'b0, 1'b1, 5'd8, 32'h22};
        vecs[6] = '{idle(), 1'b1, 1'b0, 1'b0, 5'd0, 32'h0};
        for (int i = 0; i < 7; i++) begin
            cycle(vecs[i].in, 1'b0);
            chk($sformatf("vec%0d_ready", i), {31'd0, obs_ready}, {31'd0, vecs[i].e_ready});
            chk($sformatf("vec%0d_stall", i), {31'd0, obs_stall}, {31'd0, vecs[i].e_stall});
            chk($sformatf("vec%0d_wr_en", i), {31'd0, o_wr_en}, {31'd0, vecs[i].e_wr_en});
            if (vecs[i].e_wr_en) begin
                chk($sformatf("vec%0d_addr", i), {27'd0, o_wr_addr}, {27'd0, vecs[i].e_addr});
                chk($sformatf("vec%0d_data", i), o_wr_data, vecs[i].e_data);
            end
        end

        // scoreboard: issue x9, stall on rs1=9 until the LU write retires
        t = idle(); t.iss_v = 1'b1; t.iss_rd = 5'd9;
        cycle(t, 1'b0);
        t = idle(); t.rs1 = 5'd9;
        cycle(t, 1'b0);
        chk("sb_stall_set", {31'd0, obs_stall}, 32'd1);
        t.lu_v = 1'b1; t.lu_a = 5'd9; t.lu_d = 32'h99;
        cycle(t, 1'b0);
        t = idle(); t.rs1 = 5'd9;
        cycle(t, 1'b0);
        chk("sb_wr_x9", {31'd0, o_wr_en, o_wr_addr}, {26'd0, 1'b1, 5'd9});
        cycle(t, 1'b0);
        chk("sb_stall_during_wr", {31'd0, obs_stall}, 32'd1);
        cycle(t, 1'b0);
        chk("sb_stall_cleared", {31'd0, obs_stall}, 32'd0);

        // x0 writes are consumed silently
        t = idle(); t.lu_v = 1'b1; t.lu_a = 5'd0; t.lu_d = 32'h55;
        cycle(t, 1'b0);
        cycle(idle(), 1'b0);
        chk("x0_lu_no_wr", {31'd0, o_wr_en}, 32'd0);
        cycle(idle(), 1'b0);
        chk("x0_lu_drained", {31'd0, obs_ready}, 32'd1);
        cycle(wb(5'd0, 32'h66), 1'b0);
        chk("x0_wb_no_wr", {31'd0, o_wr_en}, 32'd0);

        // WAW: reserved x4 overwritten by the pipeline
        t = idle(); t.iss_v = 1'b1; t.iss_rd = 5'd4;
        cycle(t, 1'b0);
        cycle(wb(5'd4, 32'h44), 1'b0);
        chk("waw_err", {31'd0, o_err}, 32'd1);
        chk("waw_write_done", {31'd0, o_wr_en, o_wr_addr}, {26'd0, 1'b1, 5'd4});
        for (int i = 0; i < 3; i++) cycle(idle(), 1'b0);
        chk("waw_err_sticky", {31'd0, o_err}, 32'd1);
        do_reset();
        chk("err_cleared_by_reset", {31'd0, o_err}, 32'd0);

        // reset mid-flight: two buffered entries and a reservation of x6 are discarded
        t = wb(5'd1, 32'h1); t.lu_v = 1'b1; t.lu_a = 5'd10; t.lu_d = 32'hA;
        t.iss_v = 1'b1; t.iss_rd = 5'd6;
        cycle(t, 1'b0);
        t = wb(5'd1, 32'h1); t.lu_v = 1'b1; t.lu_a = 5'd11; t.lu_d = 32'hB;
        cycle(t, 1'b0);
        cycle(idle(), 1'b1);
        chk("mid_rst_no_wr", {31'd0, o_wr_en}, 32'd0);
        t = idle(); t.rs1 = 5'd6;
        cycle(t, 1'b0);
        chk("mid_rst_ready", {31'd0, obs_ready}, 32'd1);
        chk("mid_rst_stall", {31'd0, obs_stall}, 32'd0);
        chk("mid_rst_no_buffered_wr", {31'd0, o_wr_en}, 32'd0);

        // random traffic against the model
        for (int n = 0; n < 400; n++) begin
            t.wb_v   = ($urandom_range(0, 9) < 4);
            t.wb_a   = 5'($urandom_range(0, 31));
            t.wb_d   = $urandom;
            t.lu_v   = ($urandom_range(0, 9) < 5);
            t.lu_a   = 5'($urandom_range(0, 31));
            t.lu_d   = $urandom;
            t.iss_v  = ($urandom_range(0, 9) < 3);
            t.iss_rd = 5'($urandom_range(0, 31));
            t.rs1    = 5'($urandom_range(0, 31));
            t.rs2    = 5'($urandom_range(0, 31));
            cycle(t, ($urandom_range(0, 99) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rf_wr_sched.md
RF_WR_SCHED -- requirements
Module: rf_wr_sched

Interface
REQ-001 The block SHALL have one clock, clk; reset is synchronous and active-high, port rst.
REQ-002 Ports SHALL be (name  direction  width  meaning):
- clk  in  1  clock
- rst  in  1  sync active-high reset
- i_wb_valid  in  1  pipeline writeback request; cannot be back-pressured
- i_wb_addr  in  5  writeback rd
- i_wb_data  in  32  writeback data
- i_lu_valid  in  1  long-latency-unit write request
- i_lu_addr  in  5  LU rd
- i_lu_data  in  32  LU data
- o_lu_ready  out  1  LU request accepted when valid&ready
- i_issue_valid  in  1  instruction issuing to LU, reserves rd
- i_issue_rd  in  5  reserved rd
- i_rs1, i_rs2  in  5 each  source regs of the instruction in decode
- o_stall  out  1  decode must hold
- o_wr_en, o_wr_addr, o_wr_data  out  1/5/32  register-file write port
- o_err  out  1  sticky WAW violation flag

Function
REQ-003 Write-port outputs SHALL be registered: a request selected at edge N drives o_wr_* during cycle N+1; the register file commits at edge N+1.
REQ-004 Arbitration SHALL be fixed priority: i_wb_valid wins the write port every cycle it is high.
REQ-005 LU requests SHALL enter a 2-entry FIFO; o_lu_ready = (count < 2), combinational from registered count.
REQ-006 FIFO head SHALL be selected only in cycles with i_wb_valid=0; pop and (valid&ready) push in the same cycle SHALL both occur, count unchanged.
REQ-007 With count=0, i_wb_valid=0 and an LU push, the LU data SHALL be written no earlier than one cycle after acceptance (no bypass around the FIFO).
REQ-008 Writes to x0 from either source SHALL be consumed (FIFO popped) but o_wr_en SHALL stay 0.
REQ-009 A 32-bit pending mask SHALL be kept; bit 0 is constant 0.
REQ-010 Issue SHALL take effect only when i_issue_valid=1 and o_stall=0, setting pending[i_issue_rd] (rd≠0).
REQ-011 pending[o_wr_addr] SHALL clear at the edge where o_wr_en=1 and the write originated from the FIFO; if a set of the same bit occurs the same edge, set wins.
REQ-012 o_stall (combinational) SHALL = pending[i_rs1] | pending[i_rs2] | (i_issue_valid & pending[i_issue_rd]) | (i_issue_valid & count==2).
REQ-013 o_err SHALL set, and remain set until reset, when i_wb_valid=1 with i_wb_addr≠0 and pending[i_wb_addr]=1; that write SHALL still be performed.
REQ-014 FIFO pointers SHALL wrap modulo 2; an LU request for a non-pending rd SHALL be written normally (no error).

Reset
REQ-015 While rst=1 at an edge: count=0, pointers=0, pending=0, o_wr_en=0, o_wr_addr=0, o_wr_data=0, o_err=0.
REQ-016 After reset o_lu_ready=1 and o_stall=0 for any inputs except rs1/rs2/rd referencing nothing pending (i.e. o_stall=0 unconditionally in that cycle).
REQ-017 Reset asserted mid-operation SHALL discard buffered LU entries and all reservations; no o_wr_en in the cycle following the reset edge.

Verification
REQ-018 WB only: i_wb_valid=1, addr=5, data=0xDEADBEEF -> next cycle o_wr_en=1, addr=5, data=0xDEADBEEF.
REQ-019 Contention: WB (x3) held 3 cycles, LU pushes x7=0x11 then x8=0x22 -> o_lu_ready=0 after second push; after WB drops, x7 then x8 written on consecutive cycles.
REQ-020 Scoreboard: issue rd=9; next cycle i_rs1=9 -> o_stall=1; LU writes x9 -> o_stall drops the cycle after o_wr_en for x9.
REQ-021 x0: LU push addr=0 -> FIFO count returns to 0, o_wr_en never 1; WB addr=0 -> o_wr_en=0.
REQ-022 WAW: issue rd=4, then WB addr=4 -> o_err=1 and stays 1; write to x4 still occurs.
REQ-023 Reset mid-flight: FIFO holding 2 entries, pending x6, rst=1 one cycle -> count=0, o_lu_ready=1, o_stall=0 for rs1=6, no write of buffered entries.
